// File: rtl/soc_pkg.sv
// ----------------------------------------------------------------------------
// soc_pkg
//   Shared SoC-wide definitions used by the stream blocks.
//   DATA_WIDTH : default payload width of a stream word
//   data_t     : payload type carried on every stream channel
// ----------------------------------------------------------------------------
package soc_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational rotating-priority arbiter. The search starts at ptr
//   in round-robin mode, or at index 0 in fixed-priority mode, and wraps from
//   NUM_CH-1 back to 0. The first asserted request found wins.
//
//   Ports
//     req         : per-channel request vector
//     ptr         : round-robin start index (ignored when mode = 1)
//     mode        : 0 = round-robin, 1 = fixed priority (lowest index wins)
//     grant       : one-hot grant, all-zero when nothing is requested
//     grant_idx   : binary index of the granted channel (0 when none)
//     grant_valid : high when some channel was granted
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    logic [IDX_W-1:0] start;
    int               cand;

    // Walk the channels in priority order starting at 'start'; once a winner
    // is latched into grant_valid, later candidates are ignored so the grant
    // stays one-hot.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        start       = mode ? '0 : ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = int'(start) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// ----------------------------------------------------------------------------
// rr_stream_mux
//   Merges NUM_CH valid/ready input streams into one registered output stream.
//   Arbitration is round-robin or fixed priority (selectable per cycle); the
//   output register accepts a new word whenever it is empty or being drained,
//   giving one word per cycle with a single cycle of latency.
//
//   Ports
//     clk        : clock, all state changes on the rising edge
//     rst        : synchronous active-high reset
//     mode       : 0 = round-robin, 1 = fixed priority
//     in_valid   : per-channel request
//     in_data    : per-channel payload
//     in_ready   : per-channel accept (one-hot at the granted channel)
//     out_valid  : output register holds a word
//     out_data   : registered payload
//     out_ch     : source channel index of out_data
//     out_ready  : downstream accept
// ----------------------------------------------------------------------------
module rr_stream_mux
    import soc_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = soc_pkg::DATA_WIDTH,
    localparam int IDX_W      = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [NUM_CH-1:0]     in_valid,
    input  data_t [NUM_CH-1:0]    in_data,
    output logic [NUM_CH-1:0]     in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_ch,
    input  logic                  out_ready
);

    logic                  outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0] outData_q,  outData_d;
    logic [IDX_W-1:0]      outCh_q,    outCh_d;
    logic [IDX_W-1:0]      rrPtr_q,    rrPtr_d;

    logic                  loadEn;
    logic                  fire;
    logic [NUM_CH-1:0]     grant;
    logic [IDX_W-1:0]      grantIdx;
    logic                  grantValid;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arbiter (
        .req         (in_valid),
        .ptr         (rrPtr_q),
        .mode        (mode),
        .grant       (grant),
        .grant_idx   (grantIdx),
        .grant_valid (grantValid)
    );

    // The register can take a word when it is empty or its current word
    // leaves this cycle. Reset masks every accept so nothing is consumed
    // upstream while the register is being cleared.
    assign loadEn   = !outValid_q || out_ready;
    assign fire     = loadEn && grantValid && !rst;
    assign in_ready = fire ? grant : '0;

    // A new grant reloads the register (also covering the drain-and-reload
    // case without a bubble); a drain with no grant just drops valid and
    // leaves the stale payload in place. The pointer only advances on
    // round-robin grants so fixed-priority traffic leaves it untouched.
    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outCh_d    = outCh_q;
        rrPtr_d    = rrPtr_q;
        if (fire) begin
            outValid_d = 1'b1;
            outData_d  = in_data[grantIdx];
            outCh_d    = grantIdx;
            if (!mode) begin
                rrPtr_d = (grantIdx == IDX_W'(NUM_CH - 1)) ? '0 : grantIdx + 1'b1;
            end
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outCh_q    <= '0;
            rrPtr_q    <= '0;
        end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outCh_q    <= outCh_d;
            rrPtr_q    <= rrPtr_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_ch    = outCh_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// ----------------------------------------------------------------------------
// tb_rr_stream_mux
//   Self-checking bench for rr_stream_mux (NUM_CH = 4, 8-bit payload).
//   A reference arbiter model predicts in_ready each cycle and pushes the
//   accepted word to a scoreboard queue; words are popped and compared when
//   the DUT presents them on the output.
// ----------------------------------------------------------------------------
module tb_rr_stream_mux;
    import soc_pkg::*;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    typedef struct packed {
        logic [IW-1:0] ch;
        data_t         data;
    } item_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic [N-1:0]      in_valid;
    data_t [N-1:0]     in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    data_t             out_data;
    logic [IW-1:0]     out_ch;
    logic              out_ready;

    int    checks   = 0;
    int    failures = 0;
    item_t expQ[$];
    int    mPtr;
    bit    mOutValid;

    always #5 clk = ~clk;

    rr_stream_mux #(
        .NUM_CH     (N),
        .DATA_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first valid channel searching upward from the
    // start point, wrapping; -1 when nothing is requesting.
    function automatic int model_grant(logic [N-1:0] v, logic md, int ptr);
        int start = md ? 0 : ptr;
        for (int k = 0; k < N; k++) begin
            int c = (start + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic sb_reset;
        expQ.delete();
        mPtr      = 0;
        mOutValid = 0;
    endtask

    // Advances the reference model by one cycle using the currently driven
    // inputs: reports the expected accept vector and the word the output
    // should hold right now, then applies the output transfer and any grant.
    task automatic sb_cycle(output logic [N-1:0] expRdy, output bit haveOut, output item_t front);
        int g;
        bit load;
        haveOut = mOutValid;
        front   = (expQ.size() > 0) ? expQ[0] : '0;
        g       = model_grant(in_valid, mode, mPtr);
        load    = !mOutValid || out_ready;
        expRdy  = '0;
        if (load && g >= 0) expRdy[g] = 1'b1;
        if (mOutValid && out_ready) begin
            if (expQ.size() > 0) expQ.delete(0);
            mOutValid = 0;
        end
        if (expRdy != '0) begin
            expQ.push_back('{ch: IW'(g), data: in_data[g]});
            mOutValid = 1;
            if (!mode) mPtr = (g + 1) % N;
        end
    endtask

    task automatic drain;
        logic [N-1:0] er;
        bit           ho;
        item_t        fr;
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (2) begin
            #1;
            sb_cycle(er, ho, fr);
            tick;
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = '1;
        in_data   = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%b exp=%b", in_ready, 4'b0000);
        end
        tick;
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_data !== 8'h00 || out_ch !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_out_word got=%h/%0d exp=00/0", out_data, out_ch);
        end
        checks++;
        if (dut.rrPtr_q !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_rr_ptr got=%0d exp=0", dut.rrPtr_q);
        end
        rst      = 1'b0;
        in_valid = '0;
        sb_reset();
        tick;
    endtask

    task automatic test_round_robin;
        int           expSeq [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] er;
        bit           ho;
        item_t        fr;
        in_valid  = '1;
        mode      = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            sb_cycle(er, ho, fr);
            checks++;
            if (in_ready !== er) begin
                failures++;
                $display("[TB] FAIL rr_in_ready cyc=%0d got=%b exp=%b", c, in_ready, er);
            end
            if (ho) begin
                checks++;
                if (out_ch !== fr.ch || out_data !== fr.data) begin
                    failures++;
                    $display("[TB] FAIL rr_word cyc=%0d got=%0d/%h exp=%0d/%h", c, out_ch, out_data, fr.ch, fr.data);
                end
            end
            if (c >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_ch !== IW'(expSeq[c-1])) begin
                    failures++;
                    $display("[TB] FAIL rr_sequence cyc=%0d got=v%b/ch%0d exp=v1/ch%0d", c, out_valid, out_ch, expSeq[c-1]);
                end
            end
            tick;
        end
        drain();
    endtask

    task automatic test_fixed;
        int           p0 = mPtr;
        logic [N-1:0] er;
        bit           ho;
        item_t        fr;
        in_valid  = '1;
        mode      = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            sb_cycle(er, ho, fr);
            checks++;
            if (in_ready !== 4'b0001) begin
                failures++;
                $display("[TB] FAIL fixed_in_ready cyc=%0d got=%b exp=0001", c, in_ready);
            end
            if (ho) begin
                checks++;
                if (out_ch !== 2'd0 || out_data !== 8'hAA) begin
                    failures++;
                    $display("[TB] FAIL fixed_word cyc=%0d got=%0d/%h exp=0/aa", c, out_ch, out_data);
                end
            end
            tick;
        end
        drain();
        checks++;
        if (dut.rrPtr_q !== IW'(p0)) begin
            failures++;
            $display("[TB] FAIL fixed_rr_ptr got=%0d exp=%0d", dut.rrPtr_q, p0);
        end
        mode = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [N-1:0] er;
        bit           ho;
        item_t        fr;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c >= 1) in_data[2] = 8'hC5;
            if (c == 4) out_ready = 1'b1;
            #1;
            sb_cycle(er, ho, fr);
            checks++;
            if (in_ready !== er) begin
                failures++;
                $display("[TB] FAIL bp_in_ready cyc=%0d got=%b exp=%b", c, in_ready, er);
            end
            if (c >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'hCC || out_ch !== 2'd2) begin
                    failures++;
                    $display("[TB] FAIL bp_hold cyc=%0d got=v%b/%h/%0d exp=v1/cc/2", c, out_valid, out_data, out_ch);
                end
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (in_ready !== 4'b0000) begin
                    failures++;
                    $display("[TB] FAIL bp_no_accept cyc=%0d got=%b exp=0000", c, in_ready);
                end
            end
            tick;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hC5) begin
            failures++;
            $display("[TB] FAIL bp_reload got=v%b/%h exp=v1/c5", out_valid, out_data);
        end
        drain();
        in_data[2] = 8'hCC;
    endtask

    task automatic test_wrap;
        logic [N-1:0] er;
        bit           ho;
        item_t        fr;
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        #1;
        sb_cycle(er, ho, fr);
        tick;
        drain();
        checks++;
        if (dut.rrPtr_q !== 2'd2) begin
            failures++;
            $display("[TB] FAIL wrap_setup_ptr got=%0d exp=2", dut.rrPtr_q);
        end
        in_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1;
            sb_cycle(er, ho, fr);
            checks++;
            if (in_ready !== er) begin
                failures++;
                $display("[TB] FAIL wrap_in_ready cyc=%0d got=%b exp=%b", c, in_ready, er);
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_ch !== ((c == 1) ? 2'd3 : 2'd1)) begin
                    failures++;
                    $display("[TB] FAIL wrap_order cyc=%0d got=%0d exp=%0d", c, out_ch, (c == 1) ? 3 : 1);
                end
            end
            tick;
        end
        drain();
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] er;
        bit           ho;
        item_t        fr;
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        #1;
        sb_cycle(er, ho, fr);
        tick;
        checks++;
        if (out_valid !== 1'b1 || dut.rrPtr_q === 2'd0) begin
            failures++;
            $display("[TB] FAIL midrst_setup got=v%b/ptr%0d exp=v1/ptr!=0", out_valid, dut.rrPtr_q);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midrst_in_ready got=%b exp=0000", in_ready);
        end
        tick;
        rst = 1'b0;
        sb_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || dut.rrPtr_q !== 2'd0) begin
            failures++;
            $display("[TB] FAIL midrst_state got=v%b/%h/%0d/ptr%0d exp=v0/00/0/ptr0", out_valid, out_data, out_ch, dut.rrPtr_q);
        end
        in_valid  = '1;
        out_ready = 1'b1;
        #1;
        sb_cycle(er, ho, fr);
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL midrst_first_grant got=%b exp=0001", in_ready);
        end
        tick;
        drain();
    endtask

    task automatic test_random;
        int           waitCnt [N];
        int           seq [N];
        logic [N-1:0] er;
        bit           ho;
        item_t        fr;
        for (int i = 0; i < N; i++) begin
            waitCnt[i] = 0;
            seq[i]     = 0;
        end
        in_valid = '0;
        for (int c = 0; c < 5000; c++) begin
            mode      = (c >= 4000) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
                    in_valid[i] = 1'b1;
                    in_data[i]  = {2'(i), 6'(seq[i])};
                    seq[i]++;
                    waitCnt[i] = 0;
                end
            end
            #1;
            sb_cycle(er, ho, fr);
            checks++;
            if (in_ready !== er) begin
                failures++;
                $display("[TB] FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, in_ready, er);
            end
            checks++;
            if (out_valid !== ho) begin
                failures++;
                $display("[TB] FAIL rand_out_valid cyc=%0d got=%b exp=%b", c, out_valid, ho);
            end
            if (ho) begin
                checks++;
                if (out_ch !== fr.ch || out_data !== fr.data) begin
                    failures++;
                    $display("[TB] FAIL rand_word cyc=%0d got=%0d/%h exp=%0d/%h", c, out_ch, out_data, fr.ch, fr.data);
                end
            end
            if (er != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (er[i]) begin
                        if (c < 4000) begin
                            checks++;
                            if (waitCnt[i] + 1 > N) begin
                                failures++;
                                $display("[TB] FAIL rand_starve cyc=%0d ch=%0d got=%0d exp<=%0d", c, i, waitCnt[i] + 1, N);
                            end
                        end
                    end else if (in_valid[i]) begin
                        waitCnt[i]++;
                    end
                end
            end
            tick;
            in_valid = in_valid & ~er;
        end
        mode = 1'b0;
        drain();
        checks++;
        if (expQ.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rand_drained got=q%0d/v%b exp=q0/v0", expQ.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fixed();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 Parameter: NUM_CH, default 4, number of input channels (legal 2..16).
REQ-002 Parameter: DATA_WIDTH, default soc_pkg::DATA_WIDTH (8), payload width; payload type is soc_pkg::data_t.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-006 Port: in_valid  input  NUM_CH  per-channel request.
REQ-007 Port: in_data  input  NUM_CH x DATA_WIDTH  per-channel payload (data_t array).
REQ-008 Port: in_ready  output  NUM_CH  per-channel accept; a transfer occurs when in_valid[i] && in_ready[i].
REQ-009 Port: out_valid  output  1  output register holds a word.
REQ-010 Port: out_data  output  DATA_WIDTH  registered payload.
REQ-011 Port: out_ch  output  clog2(NUM_CH)  index of the source channel of out_data.
REQ-012 Port: out_ready  input  1  downstream accept; a transfer occurs when out_valid && out_ready.

Function
REQ-013 load_en SHALL equal (!out_valid || out_ready); it is combinational from state and out_ready only.
REQ-014 When load_en=1 and at least one in_valid is set, exactly one channel g SHALL be granted, and in_ready SHALL be one-hot at bit g.
REQ-015 in_ready SHALL be all-zero when load_en=0 or when no in_valid is set.
REQ-016 In round-robin mode, g SHALL be the first asserted in_valid found searching upward from rr_ptr, wrapping from NUM_CH-1 to 0.
REQ-017 In fixed mode, g SHALL be the lowest asserted in_valid index, and rr_ptr SHALL be left unchanged.
REQ-018 On a round-robin grant, rr_ptr SHALL update to (g+1) mod NUM_CH at the next edge; rr_ptr SHALL not change in cycles without a grant.
REQ-019 On a grant, at the next edge, out_data SHALL load in_data[g], out_ch SHALL load g, and out_valid SHALL be set to 1.
REQ-020 Latency: 1 cycle from input acceptance to out_valid.
REQ-021 Throughput: 1 word per cycle while out_ready=1.
REQ-022 On an output transfer with no new grant in the same cycle, out_valid SHALL clear to 0; out_data and out_ch SHALL hold their values.
REQ-023 On a simultaneous output transfer and new grant, the register SHALL reload with the new word and out_valid SHALL stay 1, with no bubble.
REQ-024 While out_valid && !out_ready, out_data and out_ch SHALL hold stable and no input SHALL be accepted (backpressure).
REQ-025 A mode change SHALL take effect on the same cycle's grant; rr_ptr SHALL be preserved across a mode change.
REQ-026 in_data of a non-granted channel SHALL never reach out_data.

Reset
REQ-027 While rst=1 at an edge, outputs SHALL reset to: out_valid=0, out_data=0, out_ch=0; rr_ptr SHALL reset to 0.
REQ-028 While rst=1, in_ready SHALL be forced to all-zero.
REQ-029 Reset asserted mid-operation SHALL discard any held word without a transfer.
REQ-030 The first grant after reset SHALL search from channel 0.

Structure
REQ-031 soc_pkg SHALL hold DATA_WIDTH and data_t; no new package types are required, and the index width SHALL be derived locally via $clog2.
REQ-032 The rotating-priority search SHALL be a combinational sub-module rr_arbiter (inputs: req, ptr, mode; output: one-hot grant plus index), reusable elsewhere.
REQ-033 rr_stream_mux SHALL hold only the output register and rr_ptr.

Verification
REQ-034 NUM_CH=4, in_data={AA,BB,CC,DD}, all valid, mode=0, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, with no bubble.
REQ-035 Same stimulus with mode=1 -> every output is ch0 (AA); rr_ptr does not change.
REQ-036 Only ch2 valid, out_ready=0 for 3 cycles -> out_data=CC held stable for 3 cycles and in_ready=0; the word transfers when out_ready=1.
REQ-037 ch1 and ch3 valid, rr_ptr=2 -> ch3 is granted first, then ch1 (wrap-around).
REQ-038 rst asserted for 1 cycle while out_valid=1 -> next cycle out_valid=0, out_data=0, rr_ptr=0.
REQ-039 Random valid/ready over 5000 cycles against a scoreboard -> no loss, no duplication, per-channel order preserved, and each channel waits at most NUM_CH grants in mode 0.
